axi_ram_slave: RTL and testbench
================================

Name: axi_ram_slave

Overview:
- AXI3-style responder (slave) for the CPU's AXI master port (ar/r/aw/w/b channels), backed by a word-addressed internal RAM.
- Serves single-beat and INCR burst reads and writes, with a programmable read latency.
- Serves as the memory-side model in SoC simulation and as an on-chip RAM behind the CPU's AXI interface.
- Read and write channels are fully independent: one outstanding transaction per direction.

Parameters:
- MEM_AW, 12: word-index bits. RAM holds 2^MEM_AW 32-bit words (16 KiB default).
- READ_LAT, 1: cycles from AR handshake to first rvalid. Legal range 1..15.

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- arid  in  4  read ID, echoed on rid
- araddr  in  32  read start byte address
- arlen  in  8  beats-1; only arlen[3:0] honoured
- arsize  in  3  log2 bytes per beat (0..2)
- arvalid  in  1  read address valid
- arready  out  1  read address accepted
- rid  out  4  latched arid
- rdata  out  32  read data (full aligned word)
- rresp  out  2  always 2'b00 (OKAY)
- rlast  out  1  final beat of burst
- rvalid  out  1  read data valid
- rready  in  1  master accepts read data
- awid  in  4  write ID, echoed on bid
- awaddr  in  32  write start byte address
- awlen  in  4  beats-1
- awsize  in  3  log2 bytes per beat (0..2)
- awvalid  in  1  write address valid
- awready  out  1  write address accepted
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wlast  in  1  final write beat
- wvalid  in  1  write data valid
- wready  out  1  slave accepts write data
- bid  out  4  latched awid
- bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- bvalid  out  1  write response valid
- bready  in  1  master accepts response

Behaviour:
- Reset (aresetn low, asynchronous): both FSMs go to IDLE. All of arready, awready, rvalid, rlast, wready and bvalid are 0. rid, bid, rdata and rresp/bresp are 0. RAM contents are not cleared.
- arready/awready are registered. They rise on the first clock edge after reset release.
- Reset mid-burst abandons the transaction. No response is issued.
- Word index = addr[MEM_AW+1:2]. Upper address bits are ignored, so the address space aliases.
- Beat address advances by 1<<size on every accepted beat, as a 32-bit add. The index wraps modulo 2^MEM_AW.
- arburst/awburst are not ports; every burst is INCR.
- Read FSM states: R_IDLE, R_WAIT, R_DATA.
  - R_IDLE: arready=1. On arvalid&arready, latch id, addr, len[3:0] and size; load the latency counter with READ_LAT-1; arready drops.
  - R_WAIT: the counter decrements each cycle. At 0, load rdata from RAM at the current index, then go to R_DATA.
  - READ_LAT=1 therefore gives rvalid in the cycle after the AR handshake.
  - R_DATA: rvalid=1. rdata, rid and rlast are held stable while rready=0.
  - rlast=1 when beat count equals latched len.
  - On rvalid&rready: if rlast, go to R_IDLE and set arready=1 next cycle. Otherwise advance the address and load the next word; rvalid stays 1, giving back-to-back beats.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On handshake, latch id, addr, len and size; go to W_DATA with wready=1.
  - W_DATA: each wvalid&wready writes the bytes selected by wstrb at the current index that same edge, then advances the address and beat count.
  - wstrb=0 writes nothing.
  - On wlast: go to W_RESP.
  - bresp=SLVERR if the beat count differs from len+1 (early or late wlast), else OKAY. The data is still written.
  - Beats beyond len+1 without wlast keep being accepted and written.
  - W_RESP: bvalid=1, wready=0, held until bready. Then go to W_IDLE with awready=1 the next cycle.
- Simultaneous read load and write commit to the same word on one edge: rdata receives the pre-write value.
- AR and AW handshakes can occur on the same cycle. The two channels never stall each other.

Decomposition:
- Shared package axi_pkg:
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - burst type constants
  - read/write FSM state encodings
  - ID_W=4
- One natural sub-module, axi_burst_addr, instantiated once per channel. It is combinational: (addr, size) -> next addr and word index.

Test Plan:
- Single write awaddr=0x100, wdata=0xDEADBEEF, wstrb=4'hF, then read 0x100 arlen=0 -> bresp=0, bid=awid; rdata=0xDEADBEEF with rlast=1, and rvalid exactly READ_LAT cycles after the AR handshake.
- 4-beat INCR write at 0x200, size=2, data 1..4, then read with arlen=3 and rready toggling 1,0,1,0 -> rdata 1,2,3,4 in order, held during stalls, rlast only on beat 4.
- Byte strobe: 0x11223344 at 0x300, then wstrb=4'b0010 with wdata=0x0000AA00 -> read returns 0x1122AA44.
- Alias and wrap: write 0x55 at byte address 4<<MEM_AW, then read at 0 -> 0x55. A 2-beat burst starting at the last word wraps to index 0.
- awlen=3 with wlast on beat 2 -> bresp=2'b10, both beats written. Read burst overlapping a write to the same word on the same edge -> old data returned.
- Assert aresetn low mid read burst and mid write -> rvalid, wready and bvalid drop to 0 immediately. After release, arready and awready are 1 one edge later and a new transaction completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the RAM responder: response codes, burst types,
// channel FSM encodings and the latched address-phase record.
package axi_pkg;
  localparam int ID_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     addr;
    logic [3:0]      len;
    logic [2:0]      size;
  } ax_req_t;
endpackage

// File: rtl/axi_burst_addr.sv
// Beat address stepper: current word index, next byte address and its index.
module axi_burst_addr import axi_pkg::*; #(
  parameter int MEM_AW = 12
) (
  input  logic [31:0]       addr_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        burst_i,
  output logic [31:0]       nxt_addr_o,
  output logic [MEM_AW-1:0] idx_o,
  output logic [MEM_AW-1:0] nxt_idx_o
);
  always_comb begin
    nxt_addr_o = (burst_i == BURST_FIXED) ? addr_i : addr_i + (32'd1 << size_i);
  end

  // Upper address bits drop out here, so the RAM aliases across the 4 GiB space.
  assign idx_o     = addr_i[MEM_AW+1:2];
  assign nxt_idx_o = nxt_addr_o[MEM_AW+1:2];
endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 RAM responder: independent read/write channels, one outstanding burst each,
// INCR bursts up to 16 beats, programmable read latency.
module axi_ram_slave import axi_pkg::*; #(
  parameter int MEM_AW   = 12,
  parameter int READ_LAT = 1
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [3:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic            awvalid,
  output logic            awready,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);
  localparam logic [3:0] RLAT_INIT = 4'(READ_LAT - 1);

  logic [31:0] mem_q [0:(1<<MEM_AW)-1];

  rstate_e     rstate_q;
  ax_req_t     ar_q;
  logic [3:0]  rlat_q, rbeat_q;
  logic        arready_q, rvalid_q, rlast_q;
  logic [31:0] rdata_q;

  wstate_e     wstate_q;
  ax_req_t     aw_q;
  logic [3:0]  wbeat_q;
  logic        wover_q;
  logic        awready_q, wready_q, bvalid_q;
  logic [1:0]  bresp_q;

  logic [31:0]       r_nxt_addr, w_nxt_addr;
  logic [MEM_AW-1:0] r_idx, r_nxt_idx, w_idx, w_nxt_idx_unused;
  logic              wr_en;
  logic              unused_arlen;

  assign unused_arlen = ^arlen[7:4];

  axi_burst_addr #(.MEM_AW(MEM_AW)) u_rd_addr (
    .addr_i(ar_q.addr), .size_i(ar_q.size), .burst_i(BURST_INCR),
    .nxt_addr_o(r_nxt_addr), .idx_o(r_idx), .nxt_idx_o(r_nxt_idx)
  );

  axi_burst_addr #(.MEM_AW(MEM_AW)) u_wr_addr (
    .addr_i(aw_q.addr), .size_i(aw_q.size), .burst_i(BURST_INCR),
    .nxt_addr_o(w_nxt_addr), .idx_o(w_idx), .nxt_idx_o(w_nxt_idx_unused)
  );

  assign arready = arready_q;
  assign rid     = ar_q.id;
  assign rdata   = rdata_q;
  assign rresp   = RESP_OKAY;
  assign rlast   = rlast_q;
  assign rvalid  = rvalid_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bid     = aw_q.id;
  assign bresp   = bresp_q;
  assign bvalid  = bvalid_q;

  assign wr_en = (wstate_q == W_DATA) && wvalid && wready_q;

  // RAM survives reset. Read loads use non-blocking reads, so a same-edge
  // write to the same word is seen only by later loads.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rstate_q  <= R_IDLE;
      ar_q      <= '0;
      rlat_q    <= '0;
      rbeat_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arvalid && arready_q) begin
            ar_q      <= '{id: arid, addr: araddr, len: arlen[3:0], size: arsize};
            rlat_q    <= RLAT_INIT;
            rbeat_q   <= '0;
            arready_q <= 1'b0;
            rstate_q  <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rlat_q == '0) begin
            rdata_q  <= mem_q[r_idx];
            rvalid_q <= 1'b1;
            rlast_q  <= (ar_q.len == 4'd0);
            rstate_q <= R_DATA;
          end else begin
            rlat_q <= rlat_q - 4'd1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rstate_q  <= R_IDLE;
            end else begin
              ar_q.addr <= r_nxt_addr;
              rbeat_q   <= rbeat_q + 4'd1;
              rdata_q   <= mem_q[r_nxt_idx];
              rlast_q   <= (rbeat_q + 4'd1 == ar_q.len);
            end
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate_q  <= W_IDLE;
      aw_q      <= '0;
      wbeat_q   <= '0;
      wover_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awvalid && awready_q) begin
            aw_q      <= '{id: awid, addr: awaddr, len: awlen, size: awsize};
            wbeat_q   <= '0;
            wover_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wstate_q  <= W_DATA;
          end
        end
        W_DATA: begin
          if (wr_en) begin
            aw_q.addr <= w_nxt_addr;
            wbeat_q   <= wbeat_q + 4'd1;
            // Sticky: the final expected beat went by without wlast.
            if (wbeat_q == aw_q.len) wover_q <= 1'b1;
            if (wlast) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (wover_q || wbeat_q != aw_q.len) ? RESP_SLVERR : RESP_OKAY;
              wstate_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: vector table of write/read bursts plus
// hand sequences for reset, same-edge read/write collision and mid-burst reset.
module tb_axi_ram_slave;
  localparam int MEM_AW = 12, READ_LAT = 1, LIM = 60;

  logic aclk = 1'b0, aresetn = 1'b0;
  logic [3:0] arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0] arlen;
  logic [3:0] awlen, wstrb;
  logic [2:0] arsize, awsize;
  logic arvalid, arready, rvalid, rready, rlast;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [1:0] rresp, bresp;

  int checks = 0, failures = 0;

  axi_ram_slave #(.MEM_AW(MEM_AW), .READ_LAT(READ_LAT)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    bit              wr;
    logic [3:0]      id;
    logic [31:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    int              nb;
    logic [3:0]      strb;
    logic [3:0][31:0] d;
    bit              stall;
    logic [1:0]      resp;
    string           nm;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm, input int n);
    if (n >= LIM) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout after %0d cycles", nm, n);
    end
  endtask

  task automatic idle_inputs();
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arvalid = 0; rready = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
  endtask

  task automatic wr(input vec_t v);
    int n;
    @(negedge aclk);
    awid = v.id; awaddr = v.addr; awlen = v.len[3:0]; awsize = v.size; awvalid = 1;
    n = 0; while (!awready && n < LIM) begin @(negedge aclk); n++; end
    tmo({v.nm, " awready"}, n);
    @(negedge aclk);
    awvalid = 0;
    for (int b = 0; b < v.nb; b++) begin
      wdata = v.d[b]; wstrb = v.strb; wlast = (b == v.nb - 1); wvalid = 1;
      n = 0; while (!wready && n < LIM) begin @(negedge aclk); n++; end
      tmo({v.nm, " wready"}, n);
      @(negedge aclk);
    end
    wvalid = 0; wlast = 0;
    n = 0; while (!bvalid && n < LIM) begin @(negedge aclk); n++; end
    tmo({v.nm, " bvalid"}, n);
    chk({v.nm, " bresp"}, bresp, v.resp);
    chk({v.nm, " bid"}, bid, v.id);
    bready = 1;
    @(negedge aclk);
    bready = 0;
    chk({v.nm, " bvalid_drop"}, bvalid, 0);
    chk({v.nm, " awready_back"}, awready, 1);
  endtask

  task automatic rd(input vec_t v);
    int n, lat;
    @(negedge aclk);
    arid = v.id; araddr = v.addr; arlen = v.len; arsize = v.size; arvalid = 1;
    n = 0; while (!arready && n < LIM) begin @(negedge aclk); n++; end
    tmo({v.nm, " arready"}, n);
    @(negedge aclk);
    arvalid = 0;
    lat = 0; while (!rvalid && lat < LIM) begin @(negedge aclk); lat++; end
    chk({v.nm, " latency"}, lat, READ_LAT);
    chk({v.nm, " rid"}, rid, v.id);
    chk({v.nm, " rresp"}, rresp, 0);
    for (int b = 0; b <= int'(v.len[3:0]); b++) begin
      chk($sformatf("%s rdata b%0d", v.nm, b), rdata, v.d[b]);
      chk($sformatf("%s rlast b%0d", v.nm, b), rlast, b == int'(v.len[3:0]));
      if (v.stall && b > 0) begin
        rready = 0;
        @(negedge aclk);
        chk($sformatf("%s held b%0d", v.nm, b), rdata, v.d[b]);
        chk($sformatf("%s held_vld b%0d", v.nm, b), rvalid, 1);
      end
      rready = 1;
      @(negedge aclk);
      rready = 0;
    end
    chk({v.nm, " rvalid_drop"}, rvalid, 0);
    chk({v.nm, " arready_back"}, arready, 1);
  endtask

  function automatic vec_t W(logic [31:0] a, logic [3:0] len, int nb, logic [3:0] s,
                             logic [3:0][31:0] d, logic [1:0] resp, string nm);
    vec_t v;
    v = '{wr: 1, id: 4'(a[11:8] ^ 4'h3), addr: a, len: 8'(len), size: 3'd2, nb: nb,
          strb: s, d: d, stall: 0, resp: resp, nm: nm};
    return v;
  endfunction

  function automatic vec_t R(logic [31:0] a, logic [7:0] len, logic [2:0] sz, bit st,
                             logic [3:0][31:0] d, string nm);
    vec_t v;
    v = '{wr: 0, id: 4'(a[10:7] ^ 4'h9), addr: a, len: len, size: sz, nb: 0,
          strb: 4'h0, d: d, stall: st, resp: 2'b00, nm: nm};
    return v;
  endfunction

  initial begin
    idle_inputs();
    // Single, burst, strobe, alias/wrap, early/late wlast, empty strobe.
    tv.push_back(W(32'h100, 0, 1, 4'hF, {96'h0, 32'hDEADBEEF}, 2'b00, "wr_single"));
    tv.push_back(R(32'h100, 8'd0, 3'd2, 0, {96'h0, 32'hDEADBEEF}, "rd_single"));
    tv.push_back(W(32'h200, 3, 4, 4'hF, {32'd4, 32'd3, 32'd2, 32'd1}, 2'b00, "wr_burst4"));
    tv.push_back(R(32'h200, 8'd3, 3'd2, 1, {32'd4, 32'd3, 32'd2, 32'd1}, "rd_burst4_stall"));
    tv.push_back(R(32'h204, 8'hF1, 3'd0, 0, {64'h0, 32'd2, 32'd2}, "rd_size0_arlen_hi"));
    tv.push_back(W(32'h300, 0, 1, 4'hF, {96'h0, 32'h11223344}, 2'b00, "wr_strb_base"));
    tv.push_back(W(32'h300, 0, 1, 4'b0010, {96'h0, 32'h0000AA00}, 2'b00, "wr_strb_byte1"));
    tv.push_back(R(32'h300, 8'd0, 3'd2, 0, {96'h0, 32'h1122AA44}, "rd_strb"));
    tv.push_back(W(32'h4 << MEM_AW, 0, 1, 4'hF, {96'h0, 32'h55}, 2'b00, "wr_alias"));
    tv.push_back(R(32'h0, 8'd0, 3'd2, 0, {96'h0, 32'h55}, "rd_alias"));
    tv.push_back(W(32'h3FFC, 1, 2, 4'hF, {64'h0, 32'hB, 32'hA}, 2'b00, "wr_wrap"));
    tv.push_back(R(32'h3FFC, 8'd1, 3'd2, 0, {64'h0, 32'hB, 32'hA}, "rd_wrap"));
    tv.push_back(R(32'h0, 8'd0, 3'd2, 0, {96'h0, 32'hB}, "rd_wrap_idx0"));
    tv.push_back(W(32'h500, 3, 2, 4'hF, {64'h0, 32'hC2, 32'hC1}, 2'b10, "wr_early_wlast"));
    tv.push_back(R(32'h500, 8'd1, 3'd2, 0, {64'h0, 32'hC2, 32'hC1}, "rd_early"));
    tv.push_back(W(32'h600, 0, 2, 4'hF, {64'h0, 32'hE2, 32'hE1}, 2'b10, "wr_late_wlast"));
    tv.push_back(R(32'h600, 8'd1, 3'd2, 0, {64'h0, 32'hE2, 32'hE1}, "rd_late"));
    tv.push_back(W(32'h600, 0, 1, 4'h0, {96'h0, 32'hFFFFFFFF}, 2'b00, "wr_strb0"));
    tv.push_back(R(32'h600, 8'd0, 3'd2, 0, {96'h0, 32'hE1}, "rd_strb0"));
    tv.push_back(W(32'h700, 0, 1, 4'hF, {96'h0, 32'h11111111}, 2'b00, "wr_coll_base"));

    repeat (2) @(negedge aclk);
    chk("rst arready", arready, 0);
    chk("rst awready", awready, 0);
    chk("rst rvalid", rvalid, 0);
    chk("rst rlast", rlast, 0);
    chk("rst wready", wready, 0);
    chk("rst bvalid", bvalid, 0);
    chk("rst rdata", rdata, 0);
    chk("rst rid", rid, 0);
    chk("rst bid", bid, 0);
    chk("rst bresp", bresp, 0);
    aresetn = 1;
    #1 chk("rel arready_pre", arready, 0);
    @(negedge aclk);
    chk("rel arready", arready, 1);
    chk("rel awready", awready, 1);

    foreach (tv[i]) begin
      if (tv[i].wr) wr(tv[i]);
      else rd(tv[i]);
    end

    // AR and AW on one edge; write commit and read load on the next edge.
    @(negedge aclk);
    arid = 4'h6; araddr = 32'h700; arlen = 0; arsize = 2; arvalid = 1;
    awid = 4'hA; awaddr = 32'h700; awlen = 0; awsize = 2; awvalid = 1;
    chk("coll both_ready", {arready, awready}, 2'b11);
    @(negedge aclk);
    arvalid = 0; awvalid = 0;
    chk("coll wready", wready, 1);
    wdata = 32'h22222222; wstrb = 4'hF; wlast = 1; wvalid = 1;
    @(negedge aclk);
    wvalid = 0; wlast = 0;
    chk("coll rvalid", rvalid, 1);
    chk("coll old_data", rdata, 32'h11111111);
    chk("coll bvalid", bvalid, 1);
    chk("coll bresp", bresp, 0);
    rready = 1; bready = 1;
    @(negedge aclk);
    rready = 0; bready = 0;
    chk("coll done", {rvalid, bvalid}, 2'b00);
    rd(R(32'h700, 8'd0, 3'd2, 0, {96'h0, 32'h22222222}, "rd_coll_new"));

    // Reset with the read in R_DATA and the write in W_DATA.
    @(negedge aclk);
    arid = 4'h1; araddr = 32'h200; arlen = 3; arsize = 2; arvalid = 1;
    awid = 4'h2; awaddr = 32'h800; awlen = 3; awsize = 2; awvalid = 1;
    @(negedge aclk);
    arvalid = 0; awvalid = 0;
    wdata = 32'h99; wstrb = 4'hF; wlast = 0; wvalid = 1;
    @(negedge aclk);
    wvalid = 0;
    chk("mid rvalid", rvalid, 1);
    chk("mid wready", wready, 1);
    #2 aresetn = 0;
    #1;
    chk("mrst rvalid", rvalid, 0);
    chk("mrst wready", wready, 0);
    chk("mrst rlast", rlast, 0);
    chk("mrst arready", arready, 0);
    idle_inputs();
    @(negedge aclk);
    aresetn = 1;
    #1 chk("mrel arready_pre", arready, 0);
    @(negedge aclk);
    chk("mrel arready", arready, 1);
    chk("mrel awready", awready, 1);
    rd(R(32'h800, 8'd0, 3'd2, 0, {96'h0, 32'h99}, "rd_pre_reset_beat"));

    // Reset while the write response is pending.
    @(negedge aclk);
    awid = 4'h5; awaddr = 32'h900; awlen = 0; awsize = 2; awvalid = 1;
    @(negedge aclk);
    awvalid = 0;
    wdata = 32'h77; wstrb = 4'hF; wlast = 1; wvalid = 1;
    @(negedge aclk);
    wvalid = 0; wlast = 0;
    chk("resp bvalid", bvalid, 1);
    #2 aresetn = 0;
    #1 chk("rrst bvalid", bvalid, 0);
    idle_inputs();
    @(negedge aclk);
    aresetn = 1;
    @(negedge aclk);
    chk("rrel awready", awready, 1);
    rd(R(32'h100, 8'd0, 3'd2, 0, {96'h0, 32'hDEADBEEF}, "rd_ram_kept"));
    wr(W(32'h904, 1, 2, 4'hF, {64'h0, 32'h1234, 32'h5678}, 2'b00, "wr_after_rst"));
    rd(R(32'h900, 8'd2, 3'd2, 0, {32'h0, 32'h1234, 32'h5678, 32'h77}, "rd_after_rst"));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
